// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue front end and the ALU itself.
//   - Opcode / opext encodings of the 16-bit instruction word
//   - CLFZN flag bit positions
//   - Issue FSM state encoding
//   - Small decode helpers shared by the issue logic
package alu_issue_pkg;

  localparam int unsigned DataW   = 16;
  localparam int unsigned NumRegs = 16;
  localparam int unsigned AddrW   = 4;
  localparam int unsigned FlagW   = 5;

  // Primary opcodes, instr[15:12]
  localparam logic [3:0] OpRType = 4'b0000;  // register-register group
  localparam logic [3:0] OpAddi  = 4'b0101;
  localparam logic [3:0] OpAddui = 4'b0110;
  localparam logic [3:0] OpAddci = 4'b0111;
  localparam logic [3:0] OpShift = 4'b1000;  // shift group, LSH is register form
  localparam logic [3:0] OpSubi  = 4'b1001;
  localparam logic [3:0] OpRExt  = 4'b1010;  // second register-register group
  localparam logic [3:0] OpCmpi  = 4'b1011;
  localparam logic [3:0] OpMovi  = 4'b1101;
  localparam logic [3:0] OpMuli  = 4'b1110;

  // Extended opcodes, instr[7:4]
  localparam logic [3:0] ExtNop  = 4'b0000;
  localparam logic [3:0] ExtCmpu = 4'b0010;  // under OpRExt
  localparam logic [3:0] ExtLsh  = 4'b0100;  // under OpShift
  localparam logic [3:0] ExtAdd  = 4'b0101;
  localparam logic [3:0] ExtAddu = 4'b0110;
  localparam logic [3:0] ExtCmp  = 4'b1011;
  localparam logic [3:0] ExtMov  = 4'b1101;

  // CLFZN bit positions
  localparam int unsigned FlagC = 4;
  localparam int unsigned FlagL = 3;
  localparam int unsigned FlagF = 2;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagN = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2
  } state_e;

  // Register forms take B from rf[Rsrc]; everything else uses imm8.
  function automatic logic is_reg_form(input logic [3:0] op, input logic [3:0] ext);
    return (op == OpRType) || (op == OpRExt) || ((op == OpShift) && (ext == ExtLsh));
  endfunction

  // Compares only update the status register.
  function automatic logic is_cmp(input logic [3:0] op, input logic [3:0] ext);
    return ((op == OpRType) && (ext == ExtCmp)) || (op == OpCmpi) ||
           ((op == OpRExt) && (ext == ExtCmpu));
  endfunction

  function automatic logic is_nop(input logic [3:0] op, input logic [3:0] ext);
    return (op == OpRType) && (ext == ExtNop);
  endfunction

  function automatic logic [DataW-1:0] sext8(input logic [7:0] imm);
    return {{(DataW - 8){imm[7]}}, imm};
  endfunction

  function automatic logic [DataW-1:0] zext8(input logic [7:0] imm);
    return {{(DataW - 8){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile16.sv
// 16 x 16-bit register file for the ALU issue front end.
//   clk_i            rising-edge clock
//   rst_i            asynchronous active-high clear of every entry
//   raddr_a_i/_b_i   combinational read ports (operand fetch)
//   rdata_a_o/_b_o   read data
//   dbg_addr_i       debug read select
//   dbg_rdata_o      debug read data
//   we_i, waddr_i,   single synchronous write port
//   wdata_i
module regfile16
  import alu_issue_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [AddrW-1:0] raddr_a_i,
  output logic [DataW-1:0] rdata_a_o,
  input  logic [AddrW-1:0] raddr_b_i,
  output logic [DataW-1:0] rdata_b_o,
  input  logic [AddrW-1:0] dbg_addr_i,
  output logic [DataW-1:0] dbg_rdata_o,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i
);

  logic [DataW-1:0] mem_q [NumRegs];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // No write-through bypass: the issue FSM never reads in the cycle it writes.
  assign rdata_a_o   = mem_q[raddr_a_i];
  assign rdata_b_o   = mem_q[raddr_b_i];
  assign dbg_rdata_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing front end for the external combinational ALU.
// Accepts one instruction word per three cycles (IDLE -> EXEC -> WB), fetches operands
// from the internal register file, presents registered operands to the ALU, captures the
// ALU result and CLFZN flags, then writes back and updates the status register.
//   clk, reset            clock, asynchronous active-high reset
//   instr_valid/_ready    instruction handshake; instr_word carries the instruction
//   alu_opcode/_opext     decoded fields to the ALU
//   alu_a, alu_b          registered operands to the ALU
//   alu_s, alu_flags      ALU result and CLFZN flags
//   psr                   latched CLFZN
//   retire                one-cycle pulse in WB
//   dbg_addr/_rdata       combinational debug read of the register file
module alu_issue_ctrl
  import alu_issue_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [15:0]      instr_word,
  output logic             instr_ready,
  output logic [3:0]       alu_opcode,
  output logic [3:0]       alu_opext,
  output logic [DataW-1:0] alu_a,
  output logic [DataW-1:0] alu_b,
  input  logic [DataW-1:0] alu_s,
  input  logic [FlagW-1:0] alu_flags,
  output logic [FlagW-1:0] psr,
  output logic             retire,
  input  logic [AddrW-1:0] dbg_addr,
  output logic [DataW-1:0] dbg_rdata
);

  state_e state_q, state_d;

  logic [3:0]       opcode_q, opcode_d;
  logic [3:0]       opext_q, opext_d;
  logic [AddrW-1:0] rd_q, rd_d;
  logic [DataW-1:0] a_q, a_d;
  logic [DataW-1:0] b_q, b_d;
  logic [DataW-1:0] s_q, s_d;
  logic [FlagW-1:0] flags_q, flags_d;
  logic [FlagW-1:0] psr_q, psr_d;

  logic             accept;
  logic             rf_we;
  logic [DataW-1:0] rf_rdata_dest;
  logic [DataW-1:0] rf_rdata_src;

  // Instruction word fields
  logic [3:0] in_op, in_ext;
  logic [3:0] in_rd, in_rs;
  logic [7:0] in_imm;

  assign in_op  = instr_word[15:12];
  assign in_rd  = instr_word[11:8];
  assign in_ext = instr_word[7:4];
  assign in_rs  = instr_word[3:0];
  assign in_imm = instr_word[7:0];

  assign accept = instr_valid && instr_ready;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  regfile16 u_regfile (
    .clk_i      (clk),
    .rst_i      (reset),
    .raddr_a_i  (in_rd),
    .rdata_a_o  (rf_rdata_dest),
    .raddr_b_i  (in_rs),
    .rdata_b_o  (rf_rdata_src),
    .dbg_addr_i (dbg_addr),
    .dbg_rdata_o(dbg_rdata),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (s_q)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    instr_ready = 1'b0;
    retire      = 1'b0;
    rf_we       = 1'b0;
    unique case (state_q)
      StIdle:  instr_ready = 1'b1;
      StExec:  ;
      StWb: begin
        retire = 1'b1;
        rf_we  = !is_nop(opcode_q, opext_q) && !is_cmp(opcode_q, opext_q);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    opcode_d = opcode_q;
    opext_d  = opext_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    flags_d  = flags_q;
    psr_d    = psr_q;

    if (accept) begin
      opcode_d = in_op;
      opext_d  = in_ext;
      rd_d     = in_rd;

      // Operand A: Rdest, except moves which pass their source through A.
      if ((in_op == OpRType) && (in_ext == ExtMov)) begin
        a_d = rf_rdata_src;
      end else if (in_op == OpMovi) begin
        a_d = sext8(in_imm);
      end else begin
        a_d = rf_rdata_dest;
      end

      // Operand B: Rsrc for register forms, else imm8 (zero-extended only for ADDUI).
      if (is_reg_form(in_op, in_ext)) begin
        b_d = rf_rdata_src;
      end else if (in_op == OpAddui) begin
        b_d = zext8(in_imm);
      end else begin
        b_d = sext8(in_imm);
      end
    end

    if (state_q == StExec) begin
      s_d     = alu_s;
      flags_d = alu_flags;
    end

    if ((state_q == StWb) && !is_nop(opcode_q, opext_q)) begin
      psr_d = flags_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q <= '0;
      opext_q  <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      flags_q  <= '0;
      psr_q    <= '0;
    end else begin
      opcode_q <= opcode_d;
      opext_q  <= opext_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      flags_q  <= flags_d;
      psr_q    <= psr_d;
    end
  end

  assign alu_opcode = opcode_q;
  assign alu_opext  = opext_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign psr        = psr_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and a scoreboard of
// expected operands, write-back values and status register per instruction.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr_word;
  logic        instr_ready;
  logic [3:0]  alu_opcode;
  logic [3:0]  alu_opext;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_s;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        retire;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_rdata;

  alu_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr_word (instr_word),
    .instr_ready(instr_ready),
    .alu_opcode (alu_opcode),
    .alu_opext  (alu_opext),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_flags  (alu_flags),
    .psr        (psr),
    .retire     (retire),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural ALU: {CLFZN, S}
  function automatic logic [20:0] alu_f(input logic [3:0] op, input logic [3:0] ext,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    logic [15:0] s;
    logic [4:0]  f;
    sum = {1'b0, a} + {1'b0, b};
    f   = '0;
    if (op == 4'b0000 && ext == 4'b0000) begin
      s = '0;
    end else if ((op == 4'b0000 && ext == 4'b1101) || op == 4'b1101) begin
      s    = a;
      f[1] = (s == 16'h0);
      f[0] = s[15];
    end else if ((op == 4'b0000 && ext == 4'b1011) || op == 4'b1011 ||
                 (op == 4'b1010 && ext == 4'b0010)) begin
      s    = a - b;
      f[3] = (a < b);
      f[1] = (a == b);
      f[0] = ($signed(a) < $signed(b));
    end else begin
      s    = sum[15:0];
      f[4] = sum[16];
      f[2] = (a[15] == b[15]) && (s[15] != a[15]);
      f[1] = (s == 16'h0);
      f[0] = s[15];
    end
    return {f, s};
  endfunction

  assign {alu_flags, alu_s} = alu_f(alu_opcode, alu_opext, alu_a, alu_b);

  typedef struct {
    logic [15:0] word;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rd;
    logic [15:0] rd_val;
    logic [4:0]  psr;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] shadow_rf[16];
  logic [4:0]  shadow_psr;

  // Reference model of one instruction against the shadow state.
  function automatic exp_t model(input logic [15:0] w, input int acc);
    exp_t        e;
    logic [3:0]  op, ext, rd, rs;
    logic [15:0] sx, zx;
    logic [20:0] r;
    logic        regf, cmp, nop;
    op   = w[15:12];
    rd   = w[11:8];
    ext  = w[7:4];
    rs   = w[3:0];
    sx   = {{8{w[7]}}, w[7:0]};
    zx   = {8'h00, w[7:0]};
    regf = (op == 4'b0000) || (op == 4'b1010) || (op == 4'b1000 && ext == 4'b0100);
    cmp  = (op == 4'b0000 && ext == 4'b1011) || op == 4'b1011 ||
           (op == 4'b1010 && ext == 4'b0010);
    nop  = (op == 4'b0000 && ext == 4'b0000);
    e.word = w;
    e.acc  = acc;
    e.rd   = rd;
    e.a    = (op == 4'b0000 && ext == 4'b1101) ? shadow_rf[rs] :
             (op == 4'b1101) ? sx : shadow_rf[rd];
    e.b    = regf ? shadow_rf[rs] : (op == 4'b0110) ? zx : sx;
    r      = alu_f(op, ext, e.a, e.b);
    if (!nop) shadow_psr = r[20:16];
    if (!nop && !cmp) shadow_rf[rd] = r[15:0];
    e.rd_val = shadow_rf[rd];
    e.psr    = shadow_psr;
    return e;
  endfunction

  // Present a word and hold instr_valid until it is accepted. n counts cycles spent
  // waiting for instr_ready; acc is the cycle count just after the accepting edge.
  task automatic issue(input logic [15:0] w, input bit push, output int acc, output int n);
    n = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_word  = w;
    while (!instr_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!instr_ready) begin
      check_eq("accept_timeout", 32'(instr_ready), 32'd1);
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) sb.push_back(model(w, acc));
  endtask

  task automatic drop();
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic run1(input logic [15:0] w);
    int acc, n;
    issue(w, 1'b1, acc, n);
    drop();
  endtask

  // Scoreboard monitor: operands and latency at retire, committed state one cycle later.
  initial begin
    exp_t cur;
    bit   chk_pending;
    chk_pending = 1'b0;
    dbg_addr    = '0;
    forever begin
      @(negedge clk);
      if (chk_pending) begin
        check_eq("wb_rf", 32'(dbg_rdata), 32'(cur.rd_val));
        check_eq("wb_psr", 32'(psr), 32'(cur.psr));
        chk_pending = 1'b0;
      end
      if (retire === 1'b1) begin
        if (sb.size() == 0) begin
          check_eq("spurious_retire", 32'(retire), 32'd0);
        end else begin
          cur = sb.pop_front();
          check_eq("alu_a", 32'(alu_a), 32'(cur.a));
          check_eq("alu_b", 32'(alu_b), 32'(cur.b));
          check_eq("alu_op", 32'({alu_opcode, alu_opext}), 32'({cur.word[15:12], cur.word[7:4]}));
          // The edge closing this cycle is the second after the accept.
          check_eq("retire_latency", 32'(cyc + 1 - cur.acc), 32'd2);
          dbg_addr    = cur.rd;
          chk_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    int acc1, acc2, n1, n2;
    logic [15:0] w;
    logic [3:0]  pick;
    instr_valid = 1'b0;
    instr_word  = '0;
    reset       = 1'b1;
    for (int i = 0; i < 16; i++) shadow_rf[i] = '0;
    shadow_psr = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(instr_ready), 32'd1);
    check_eq("rst_retire", 32'(retire), 32'd0);
    check_eq("rst_psr", 32'(psr), 32'd0);
    check_eq("rst_alu_a", 32'(alu_a), 32'd0);
    check_eq("rst_alu_b", 32'(alu_b), 32'd0);
    check_eq("rst_alu_op", 32'({alu_opcode, alu_opext}), 32'd0);
    check_eq("rst_rf0", 32'(dbg_rdata), 32'd0);
    reset = 1'b0;

    // Immediates, sign vs zero extension
    run1(16'h5105);
    run1(16'h51FF);
    run1(16'h64FF);
    run1(16'hD780);
    // Register add and moves
    run1(16'h02D1);
    run1(16'h0251);
    run1(16'h06D1);
    // Compares and NOP
    run1(16'h01B1);
    run1(16'h0000);
    run1(16'hB780);
    run1(16'hA272);

    // Backpressure: second word held while the first executes
    issue(16'h0321, 1'b1, acc1, n1);
    issue(16'h6301, 1'b1, acc2, n2);
    drop();
    check_eq("bp_spacing", 32'(acc2 - acc1), 32'd3);
    check_eq("bp_ready_low", 32'(n2), 32'd2);

    // Random mix over the modelled instruction set
    for (int k = 0; k < 12; k++) begin
      pick = 4'($urandom_range(0, 6));
      w    = 16'($urandom);
      unique case (pick)
        4'd0: w[15:12] = 4'b0101;
        4'd1: w[15:12] = 4'b0110;
        4'd2: w[15:12] = 4'b1101;
        4'd3: w[15:12] = 4'b1011;
        4'd4: begin w[15:12] = 4'b0000; w[7:4] = 4'b0101; end
        4'd5: begin w[15:12] = 4'b0000; w[7:4] = 4'b1101; end
        default: begin w[15:12] = 4'b0000; w[7:4] = 4'b1011; end
      endcase
      run1(w);
    end
    repeat (4) @(negedge clk);

    // Reset during EXEC: instruction dropped, nothing retires
    issue(16'h5501, 1'b0, acc1, n1);
    instr_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_ready", 32'(instr_ready), 32'd1);
    check_eq("midrst_retire", 32'(retire), 32'd0);
    check_eq("midrst_psr", 32'(psr), 32'd0);
    check_eq("midrst_alu_a", 32'(alu_a), 32'd0);
    for (int i = 0; i < 16; i++) shadow_rf[i] = '0;
    shadow_psr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run1(16'h5501);
    run1(16'h0251);

    for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
